vblank_update_sequencer: RTL
============================

Name: vblank_update_sequencer

Overview:
- Schedules position/state updates for up to N on-screen widgets so that widget registers change only during vertical blanking.
- Divides the frame rate with a frame counter. On a selected VBlank rising edge it issues a one-hot update request to each widget in turn and waits for each widget's done acknowledge, with a timeout.
- Sits between the VGA low-level driver (VBlank source) and the widget instances. It replaces the free-running 10 Hz divider as the widget update enable.

Parameters:
- N_WIDGETS, 4, number of widgets sequenced (min 1).
- IDX_W, 2, width of the widget index; must be at least clog2(N_WIDGETS), and 1 when N_WIDGETS=1.
- FRAME_DIV, 6, number of VBlank rising edges per update sequence (min 1; 6 gives 10 Hz at 60 Hz refresh).
- TIMEOUT, 16, number of WAIT cycles allowed per widget before it is skipped (min 1).

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-low reset.
- VBlank  in  1  vertical blanking flag from the VGA driver, synchronous to clk.
- enable  in  1  when 0, the frame counter holds and no new sequence starts.
- upd_done  in  N_WIDGETS  per-widget update-complete acknowledge, level or pulse.
- clear_err  in  1  clears the sticky error flags.
- upd_req  out  N_WIDGETS  one-hot, one-cycle update request.
- cur_idx  out  IDX_W  index of the widget currently being serviced.
- busy  out  1  high while a sequence is in progress.
- frame_tick  out  1  one-cycle pulse when a sequence starts.
- overrun  out  1  sticky: VBlank ended before the sequence finished.
- timeout_err  out  1  sticky: at least one widget failed to acknowledge in time.

Behaviour:
- Only one clock is used. reset is synchronous and active-low.
- Reset (reset=0 at a clk edge) values:
  - State IDLE; upd_req=0; cur_idx=0; busy=0; frame_tick=0; overrun=0; timeout_err=0.
  - frame_cnt=0; wait timer=0.
  - vblank_d=1, so VBlank already high at reset release does not produce an edge.
- Edge detect: rise = VBlank & ~vblank_d; vblank_d is registered every cycle.
- Frame counter:
  - On rise with enable=1: if frame_cnt==FRAME_DIV-1, then frame_cnt←0 and a sequence starts (when in IDLE); otherwise frame_cnt increments.
  - enable=0: frame_cnt holds. An in-progress sequence still completes.
- FSM states: IDLE, REQ, WAIT. Outputs are registered and Moore-style.
  - IDLE → REQ on a sequence start; cur_idx←0.
    - Cycle E is the rise cycle. In cycle E+1: frame_tick=1 (one cycle), state=REQ, busy=1.
  - REQ: upd_req[cur_idx]=1 for exactly this cycle; timer←0; next state WAIT. upd_done is ignored in REQ.
  - WAIT: upd_req=0.
    - If upd_done[cur_idx]=1: advance.
    - Else if timer==TIMEOUT-1: set timeout_err and advance (widget skipped).
    - Else timer increments.
    - Advance means: if cur_idx==N_WIDGETS-1 go to IDLE (busy=0 next cycle, cur_idx←0); else cur_idx+1 and go to REQ.
  - upd_done bits of non-current widgets are ignored.
- Abort: VBlank=0 while state≠IDLE → next cycle IDLE, busy=0, upd_req=0, cur_idx=0, overrun←1. Abort has priority over done and timeout in the same cycle.
- Sticky flags: clear_err=1 clears overrun and timeout_err. If a set condition occurs in the same cycle, set wins.
- Minimum sequence length with immediate acks is 2·N_WIDGETS cycles of busy.
- Reset asserted mid-sequence → reset values on the next cycle; no further requests.

Test Plan:
All scenarios use N_WIDGETS=4, IDX_W=2, FRAME_DIV=3, TIMEOUT=8.
1. Reset with VBlank held 1, then release → no frame_tick, no upd_req; all outputs 0 for 20 cycles.
2. Six VBlank rising edges; each widget raises upd_done in the first WAIT cycle → frame_tick only after edges 3 and 6. In each sequence, upd_req = 0001, 0010, 0100, 1000 at E+1, E+3, E+5, E+7. busy high E+1..E+8; errors stay 0.
3. Widget 1 never acks → upd_req[1] at E+3. After 8 WAIT cycles, timeout_err=1 at E+12 and upd_req[2]=1 at E+12. Sequence then completes; overrun=0.
4. VBlank drops while in WAIT for widget 2 → next cycle busy=0 and overrun=1; upd_req[3] never asserted. The next 3rd rise starts a fresh sequence at widget 0.
5. clear_err pulsed in the same cycle as a new timeout → timeout_err stays 1. clear_err alone → both flags 0 next cycle.
6. enable=0 across 5 edges, then enable=1 → frame_cnt unchanged; the first tick occurs after the 3rd enabled-count edge total. reset=0 asserted at E+4 of a sequence → next cycle all outputs 0.

Source files
------------

// File: rtl/vblank_update_sequencer.sv
// Frame-divided update scheduler: on every FRAME_DIV-th VBlank rising edge it walks the
// widgets in order, issuing a one-cycle request to each and waiting (bounded) for its ack.
module vblank_update_sequencer #(
  parameter int N_WIDGETS = 4,
  parameter int IDX_W     = 2,
  parameter int FRAME_DIV = 6,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 VBlank,
  input  logic                 enable,
  input  logic [N_WIDGETS-1:0] upd_done,
  input  logic                 clear_err,
  output logic [N_WIDGETS-1:0] upd_req,
  output logic [IDX_W-1:0]     cur_idx,
  output logic                 busy,
  output logic                 frame_tick,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int TM_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_DIV - 1);
  localparam logic [TM_W-1:0]  TM_LAST  = TM_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WIDGETS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [FC_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [TM_W-1:0]      timer_q, timer_d;
  logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;
  logic [N_WIDGETS-1:0] upd_req_q, upd_req_d;
  logic                 busy_q, busy_d;
  logic                 frame_tick_q, frame_tick_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 vblank_q;

  logic rise;
  logic seq_start;
  logic advance;
  logic set_timeout;
  logic set_overrun;

  assign rise = VBlank & ~vblank_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    seq_start     = 1'b0;
    state_d       = state_q;
    cur_idx_d     = cur_idx_q;
    timer_d       = timer_q;
    advance       = 1'b0;
    set_timeout   = 1'b0;
    set_overrun   = 1'b0;
    upd_req_d     = '0;

    if (rise && enable) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d = '0;
        seq_start   = (state_q == S_IDLE);
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (seq_start) begin
          state_d   = S_REQ;
          cur_idx_d = '0;
        end
      end
      S_REQ: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (upd_done[cur_idx_q]) begin
          advance = 1'b1;
        end else if (timer_q == TM_LAST) begin
          set_timeout = 1'b1;
          advance     = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (cur_idx_q == IDX_LAST) begin
        state_d   = S_IDLE;
        cur_idx_d = '0;
      end else begin
        state_d   = S_REQ;
        cur_idx_d = cur_idx_q + 1'b1;
      end
    end

    // Blanking ended mid-sequence: drop everything, the skipped widgets wait for the next frame.
    if (state_q != S_IDLE && !VBlank) begin
      state_d     = S_IDLE;
      cur_idx_d   = '0;
      set_timeout = 1'b0;
      set_overrun = 1'b1;
    end

    if (state_d == S_REQ) begin
      upd_req_d[cur_idx_d] = 1'b1;
    end

    busy_d        = (state_d != S_IDLE);
    frame_tick_d  = seq_start;
    overrun_d     = set_overrun | (overrun_q & ~clear_err);
    timeout_err_d = set_timeout | (timeout_err_q & ~clear_err);
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      frame_cnt_q   <= '0;
      timer_q       <= '0;
      cur_idx_q     <= '0;
      upd_req_q     <= '0;
      busy_q        <= 1'b0;
      frame_tick_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      vblank_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      timer_q       <= timer_d;
      cur_idx_q     <= cur_idx_d;
      upd_req_q     <= upd_req_d;
      busy_q        <= busy_d;
      frame_tick_q  <= frame_tick_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      vblank_q      <= VBlank;
    end
  end

  assign upd_req     = upd_req_q;
  assign cur_idx     = cur_idx_q;
  assign busy        = busy_q;
  assign frame_tick  = frame_tick_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule
